// File: rtl/sun_tracker.sv
// sun_tracker: steps azimuth/elevation motors toward the brightest of four
// lux readings and parks the collector at home (0,0) when all are dark.
module sun_tracker #(
   parameter int POS_W       = 8,
   parameter int POS_MAX     = 255,
   parameter int DEADBAND    = 8,
   parameter int DARK_LUX    = 5,
   parameter int STEP_PERIOD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_valid,
   input  logic [7:0]       n_lux,
   input  logic [7:0]       e_lux,
   input  logic [7:0]       s_lux,
   input  logic [7:0]       w_lux,
   output logic             az_step,
   output logic             az_dir,
   output logic             el_step,
   output logic             el_dir,
   output logic [POS_W-1:0] az_pos,
   output logic [POS_W-1:0] el_pos,
   output logic             busy,
   output logic             parked
);

   localparam int CNT_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_PERIOD - 1);
   localparam logic signed [8:0] DB = 9'(DEADBAND);
   localparam logic [POS_W-1:0] PMAX = POS_W'(POS_MAX);
   localparam logic [7:0] DARK = 8'(DARK_LUX);

   typedef enum logic [2:0] {
      IDLE,
      EVAL,
      AZ_STEP,
      AZ_WAIT,
      EL_STEP,
      EL_WAIT,
      PARK_STEP,
      PARK_WAIT
   } state_t;

   state_t state_q, state_d;

   logic [7:0] n_q, n_d;
   logic [7:0] e_q, e_d;
   logic [7:0] s_q, s_d;
   logic [7:0] w_q, w_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             az_step_q, az_step_d;
   logic             az_dir_q, az_dir_d;
   logic             el_step_q, el_step_d;
   logic             el_dir_q, el_dir_d;
   logic [POS_W-1:0] az_pos_q, az_pos_d;
   logic [POS_W-1:0] el_pos_q, el_pos_d;
   logic             busy_q, busy_d;
   logic             parked_q, parked_d;

   logic signed [8:0] d_ew;
   logic signed [8:0] d_ns;

   logic dark;
   logic az_east;
   logic az_need;
   logic el_north;
   logic el_need;
   logic at_home;
   logic park_az;
   logic cnt_done;

   assign d_ew = $signed({1'b0, e_q}) - $signed({1'b0, w_q});
   assign d_ns = $signed({1'b0, n_q}) - $signed({1'b0, s_q});

   // Step decisions always use the latched sample and current positions
   always_comb begin
      dark = (n_q < DARK) && (e_q < DARK) &&
             (s_q < DARK) && (w_q < DARK);
      az_east = d_ew > DB;
      az_need = (az_east && (az_pos_q < PMAX)) ||
                ((d_ew < -DB) && (az_pos_q != '0));
      el_north = d_ns > DB;
      el_need = (el_north && (el_pos_q < PMAX)) ||
                ((d_ns < -DB) && (el_pos_q != '0));
      at_home = (az_pos_q == '0) && (el_pos_q == '0);
      park_az = az_pos_q != '0;
      cnt_done = cnt_q == CNT_LAST;
   end

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      e_d       = e_q;
      s_d       = s_q;
      w_d       = w_q;
      cnt_d     = cnt_q;
      az_step_d = 1'b0;
      el_step_d = 1'b0;
      az_dir_d  = az_dir_q;
      el_dir_d  = el_dir_q;
      az_pos_d  = az_pos_q;
      el_pos_d  = el_pos_q;
      parked_d  = parked_q;

      unique case (state_q)
         IDLE: begin
            if (sample_valid) begin
               n_d     = n_lux;
               e_d     = e_lux;
               s_d     = s_lux;
               w_d     = w_lux;
               state_d = EVAL;
            end
         end
         EVAL: begin
            if (dark) begin
               if (at_home) begin
                  parked_d = 1'b1;
                  state_d  = IDLE;
               end else begin
                  state_d = PARK_STEP;
                  if (park_az) begin
                     az_step_d = 1'b1;
                     az_dir_d  = 1'b0;
                  end else begin
                     el_step_d = 1'b1;
                     el_dir_d  = 1'b0;
                  end
               end
            end else begin
               parked_d = 1'b0;
               if (az_need) begin
                  az_step_d = 1'b1;
                  az_dir_d  = az_east;
                  state_d   = AZ_STEP;
               end else if (el_need) begin
                  el_step_d = 1'b1;
                  el_dir_d  = el_north;
                  state_d   = EL_STEP;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         AZ_STEP: begin
            az_pos_d = az_dir_q ? az_pos_q + POS_W'(1)
                                : az_pos_q - POS_W'(1);
            cnt_d    = '0;
            state_d  = AZ_WAIT;
         end
         AZ_WAIT: begin
            if (!cnt_done) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else if (el_need) begin
               el_step_d = 1'b1;
               el_dir_d  = el_north;
               state_d   = EL_STEP;
            end else begin
               state_d = IDLE;
            end
         end
         EL_STEP: begin
            el_pos_d = el_dir_q ? el_pos_q + POS_W'(1)
                                : el_pos_q - POS_W'(1);
            cnt_d    = '0;
            state_d  = EL_WAIT;
         end
         EL_WAIT: begin
            if (!cnt_done) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               state_d = IDLE;
            end
         end
         PARK_STEP: begin
            // The pulse raised on entry tells which axis moved
            if (az_step_q) begin
               az_pos_d = az_pos_q - POS_W'(1);
            end else begin
               el_pos_d = el_pos_q - POS_W'(1);
            end
            cnt_d   = '0;
            state_d = PARK_WAIT;
         end
         PARK_WAIT: begin
            if (!cnt_done) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else if (at_home) begin
               parked_d = 1'b1;
               state_d  = IDLE;
            end else begin
               state_d = PARK_STEP;
               if (park_az) begin
                  az_step_d = 1'b1;
                  az_dir_d  = 1'b0;
               end else begin
                  el_step_d = 1'b1;
                  el_dir_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = state_d != IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         n_q       <= '0;
         e_q       <= '0;
         s_q       <= '0;
         w_q       <= '0;
         cnt_q     <= '0;
         az_step_q <= 1'b0;
         az_dir_q  <= 1'b0;
         el_step_q <= 1'b0;
         el_dir_q  <= 1'b0;
         az_pos_q  <= '0;
         el_pos_q  <= '0;
         busy_q    <= 1'b0;
         parked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         e_q       <= e_d;
         s_q       <= s_d;
         w_q       <= w_d;
         cnt_q     <= cnt_d;
         az_step_q <= az_step_d;
         az_dir_q  <= az_dir_d;
         el_step_q <= el_step_d;
         el_dir_q  <= el_dir_d;
         az_pos_q  <= az_pos_d;
         el_pos_q  <= el_pos_d;
         busy_q    <= busy_d;
         parked_q  <= parked_d;
      end
   end

   assign az_step = az_step_q;
   assign az_dir  = az_dir_q;
   assign el_step = el_step_q;
   assign el_dir  = el_dir_q;
   assign az_pos  = az_pos_q;
   assign el_pos  = el_pos_q;
   assign busy    = busy_q;
   assign parked  = parked_q;

endmodule

// File: tb/tb_sun_tracker.sv
// tb_sun_tracker: table vectors, hand corner sequences and random samples,
// each checked cycle by cycle against a pulse-schedule model.
module tb_sun_tracker;

   localparam int SP   = 4;
   localparam int DB   = 8;
   localparam int DARK = 5;
   localparam int PMAX = 255;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_valid = 1'b0;
   logic [7:0] n_lux = '0;
   logic [7:0] e_lux = '0;
   logic [7:0] s_lux = '0;
   logic [7:0] w_lux = '0;
   logic       az_step, az_dir, el_step, el_dir, busy, parked;
   logic [7:0] az_pos, el_pos;

   int vecs = 0;
   int errs = 0;
   int m_az = 0;
   int m_el = 0;
   int m_parked = 0;

   always #5 clk = ~clk;

   sun_tracker #(
      .POS_W(8),
      .POS_MAX(PMAX),
      .DEADBAND(DB),
      .DARK_LUX(DARK),
      .STEP_PERIOD(SP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sample_valid(sample_valid),
      .n_lux(n_lux),
      .e_lux(e_lux),
      .s_lux(s_lux),
      .w_lux(w_lux),
      .az_step(az_step),
      .az_dir(az_dir),
      .el_step(el_step),
      .el_dir(el_dir),
      .az_pos(az_pos),
      .el_pos(el_pos),
      .busy(busy),
      .parked(parked)
   );

   task automatic chk(input string nm, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && az_step && el_step) begin
         errs++;
         $display("FAIL both_steps: az_step=1 el_step=1, expected never both");
      end
   end

   // Model: list the pulses (cycle, axis, dir) the sample should produce
   task automatic apply(input logic [7:0] n, input logic [7:0] e,
                        input logic [7:0] s, input logic [7:0] w,
                        input int poke);
      int  pj[$];
      bit  pax[$];
      bit  pdir[$];
      int  dew, dns, nb, ns, k;
      bit  dark, ea, ee;
      dark = (n < DARK) && (e < DARK) && (s < DARK) && (w < DARK);
      if (dark) begin
         for (int i = 0; i < m_az; i++) begin
            pj.push_back(2 + i * (SP + 1));
            pax.push_back(1'b0);
            pdir.push_back(1'b0);
         end
         for (int i = 0; i < m_el; i++) begin
            pj.push_back(2 + (m_az + i) * (SP + 1));
            pax.push_back(1'b1);
            pdir.push_back(1'b0);
         end
         nb = 1 + (m_az + m_el) * (SP + 1);
         m_az = 0;
         m_el = 0;
         m_parked = 1;
      end else begin
         m_parked = 0;
         ns = 0;
         dew = int'(e) - int'(w);
         dns = int'(n) - int'(s);
         if ((dew > DB && m_az < PMAX) || (dew < -DB && m_az > 0)) begin
            pj.push_back(2);
            pax.push_back(1'b0);
            pdir.push_back(dew > 0);
            m_az += (dew > 0) ? 1 : -1;
            ns++;
         end
         if ((dns > DB && m_el < PMAX) || (dns < -DB && m_el > 0)) begin
            pj.push_back(2 + ns * (SP + 1));
            pax.push_back(1'b1);
            pdir.push_back(dns > 0);
            m_el += (dns > 0) ? 1 : -1;
            ns++;
         end
         nb = 1 + ns * (SP + 1);
      end

      n_lux = n;
      e_lux = e;
      s_lux = s;
      w_lux = w;
      sample_valid = 1'b1;
      @(posedge clk);
      #1 sample_valid = 1'b0;
      k = 0;
      for (int j = 1; j <= nb + 1; j++) begin
         @(negedge clk);
         ea = (k < pj.size()) && (pj[k] == j) && !pax[k];
         ee = (k < pj.size()) && (pj[k] == j) && pax[k];
         chk("busy", int'(busy), int'(j <= nb));
         chk("az_step", int'(az_step), int'(ea));
         chk("el_step", int'(el_step), int'(ee));
         if (ea) chk("az_dir", int'(az_dir), int'(pdir[k]));
         if (ee) chk("el_dir", int'(el_dir), int'(pdir[k]));
         if (ea || ee) k++;
         sample_valid = (j == poke);
         if (j == poke) begin
            n_lux = 8'd255;
            e_lux = 8'd255;
            s_lux = 8'd0;
            w_lux = 8'd0;
         end
      end
      chk("az_pos", int'(az_pos), m_az);
      chk("el_pos", int'(el_pos), m_el);
      chk("parked", int'(parked), m_parked);
   endtask

   typedef struct {
      logic [7:0] n, e, s, w;
      int         az, el, pk;
   } vec_t;

   vec_t tbl[13];

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit seen;
      tbl[0]  = '{8'd60,  8'd100, 8'd60,  8'd50,  1, 0, 0};
      tbl[1]  = '{8'd70,  8'd58,  8'd40,  8'd50,  1, 1, 0};
      tbl[2]  = '{8'd40,  8'd50,  8'd70,  8'd58,  1, 0, 0};
      tbl[3]  = '{8'd0,   8'd50,  8'd0,   8'd59,  0, 0, 0};
      tbl[4]  = '{8'd100, 8'd10,  8'd100, 8'd90,  0, 0, 0};
      tbl[5]  = '{8'd0,   8'd0,   8'd200, 8'd0,   0, 0, 0};
      tbl[6]  = '{8'd4,   8'd4,   8'd4,   8'd4,   0, 0, 1};
      tbl[7]  = '{8'd20,  8'd90,  8'd20,  8'd10,  1, 0, 0};
      tbl[8]  = '{8'd100, 8'd30,  8'd91,  8'd30,  1, 1, 0};
      tbl[9]  = '{8'd255, 8'd200, 8'd0,   8'd0,   2, 2, 0};
      tbl[10] = '{8'd5,   8'd5,   8'd5,   8'd5,   2, 2, 0};
      tbl[11] = '{8'd5,   8'd4,   8'd4,   8'd4,   2, 2, 0};
      tbl[12] = '{8'd0,   8'd0,   8'd0,   8'd0,   0, 0, 1};

      #1 rst = 1'b0;
      #2;
      chk("rst_az_step", int'(az_step), 0);
      chk("rst_el_step", int'(el_step), 0);
      chk("rst_az_dir", int'(az_dir), 0);
      chk("rst_el_dir", int'(el_dir), 0);
      chk("rst_az_pos", int'(az_pos), 0);
      chk("rst_el_pos", int'(el_pos), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_parked", int'(parked), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 13; i++) begin
         apply(tbl[i].n, tbl[i].e, tbl[i].s, tbl[i].w, 0);
         chk("tbl_az", int'(az_pos), tbl[i].az);
         chk("tbl_el", int'(el_pos), tbl[i].el);
         chk("tbl_parked", int'(parked), tbl[i].pk);
      end

      for (int i = 0; i < 10; i++) apply(8'd60, 8'd100, 8'd60, 8'd50, 0);
      apply(8'd60, 8'd100, 8'd60, 8'd50, 0);
      chk("east_az", int'(az_pos), 11);
      chk("east_el", int'(el_pos), 0);

      for (int i = 0; i < 244; i++) apply(8'd60, 8'd100, 8'd60, 8'd50, 0);
      chk("limit_reach", int'(az_pos), 255);
      apply(8'd60, 8'd200, 8'd60, 8'd0, 0);
      chk("clamp_az", int'(az_pos), 255);
      chk("clamp_busy", int'(busy), 0);

      n_lux = 8'd60;
      e_lux = 8'd50;
      s_lux = 8'd60;
      w_lux = 8'd100;
      sample_valid = 1'b1;
      @(posedge clk);
      #1 sample_valid = 1'b0;
      seen = 1'b0;
      for (int j = 0; j < 6 && !seen; j++) begin
         @(negedge clk);
         if (az_step) seen = 1'b1;
      end
      chk("midstep_seen", int'(seen), 1);
      rst = 1'b0;
      #1;
      chk("midrst_az_step", int'(az_step), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_az_pos", int'(az_pos), 0);
      chk("midrst_az_dir", int'(az_dir), 0);
      chk("midrst_el_pos", int'(el_pos), 0);
      chk("midrst_parked", int'(parked), 0);
      @(negedge clk);
      rst = 1'b1;
      m_az = 0;
      m_el = 0;
      m_parked = 0;

      for (int i = 0; i < 3; i++) apply(8'd60, 8'd100, 8'd60, 8'd50, 0);
      for (int i = 0; i < 2; i++) apply(8'd100, 8'd50, 8'd0, 8'd50, 0);
      chk("prepark_az", int'(az_pos), 3);
      chk("prepark_el", int'(el_pos), 2);
      apply(8'd4, 8'd4, 8'd4, 8'd4, 4);
      chk("park_az", int'(az_pos), 0);
      chk("park_el", int'(el_pos), 0);
      chk("park_flag", int'(parked), 1);
      apply(8'd20, 8'd90, 8'd20, 8'd10, 0);
      chk("unpark_flag", int'(parked), 0);
      chk("unpark_az", int'(az_pos), 1);

      for (int i = 0; i < 300; i++) begin
         int r, base;
         logic [7:0] a, b, c, d;
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            a = 8'($urandom_range(0, DARK));
            b = 8'($urandom_range(0, DARK));
            c = 8'($urandom_range(0, DARK));
            d = 8'($urandom_range(0, DARK));
         end else if (r < 5) begin
            base = int'($urandom_range(20, 200));
            a = 8'(base + int'($urandom_range(0, 20)) - 10);
            b = 8'(base + int'($urandom_range(0, 20)) - 10);
            c = 8'(base + int'($urandom_range(0, 20)) - 10);
            d = 8'(base + int'($urandom_range(0, 20)) - 10);
         end else begin
            a = 8'($urandom);
            b = 8'($urandom);
            c = 8'($urandom);
            d = 8'($urandom);
         end
         apply(a, b, c, d, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
